logic1: RTL and testbench
=========================

# logic1

Two-input, two-output clocked Moore sequence machine. It watches a 2-bit input pair (X1, X2) for the ordered pattern 11 → {00/01} → 10. It flags each phase of the pattern on (Z1, Z2), then returns to idle on the closing 11. It is a small control leaf: one clock domain, no handshakes, outputs taken straight from state flops.

## Interface
- No parameters.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- X  input  2  X[1] = X1, X[0] = X2. Sampled on rising clk; the driver keeps X synchronous to clk.
- Z1  output  1  state bit 1 (registered).
- Z2  output  1  state bit 0 (registered).

## Operation
- 2-bit state S, encoded so that {Z1, Z2} = S at all times. Outputs are never combinational from X.

States and encodings:
- IDLE = 00
- ARM = 11
- HOLD = 10
- FIRE = 01

Transitions, evaluated on each rising clk with the current X:
- IDLE
  - X=11 → ARM
  - X=00, 01 or 10 → IDLE
- ARM
  - X=11 → ARM
  - X=00, 01 or 10 → HOLD
- HOLD
  - X=00 or 01 → HOLD
  - X=10 → FIRE
  - X=11 → IDLE
- FIRE
  - X=10 → FIRE
  - X=11, 00 or 01 → IDLE

Reference behaviour from reset, with X applied one per cycle:
- X sequence: 00, 01, 11, 01, 00, 10, 11, 01.
- {Z1,Z2} sequence: 00, 00, 11, 10, 10, 01, 00, 00.
- Repeating the X sequence repeats the output sequence exactly, because it ends in IDLE.

Next-state equations (Xa = X[1], Xb = X[0]), binding for both build variants:
- S1' = (S==IDLE & Xa & Xb) | (S==ARM) | (S==HOLD & ~Xa)
- S0' = (S==IDLE & Xa & Xb) | (S==ARM & Xa & Xb) | (S==HOLD & Xa & ~Xb) | (S==FIRE & Xa & ~Xb)

## Timing
- Reset: rst=1 forces S=IDLE immediately, without waiting for clk. Z1=0 and Z2=0 while rst is high.
- First evaluated edge: the first rising clk with rst=0 evaluates X. Reset deasserted mid-pattern always restarts from IDLE.
- Latency: exactly 1 cycle. X valid before edge n → Z reflects the new state after edge n.
- Input holding: X held for k cycles evaluates k times. Holding is idempotent in every state except IDLE+11, which moves to ARM; ARM then holds on 11.
- No X/Z propagation: an unknown X leaves the state unspecified. The bench drives only 0/1.

## Configuration
- LOGIC1_STRUCT_EN
  - Defined: the state register is two explicit async-reset DFF instances. Next-state logic is built only from gate primitives (and/or/not) implementing the equations above.
  - Undefined: behavioral case statement on S inside one always block with async reset.
- Both builds are cycle-for-cycle and bit-identical at the ports. The bench runs unchanged against either build.

## Test plan
- Reset: assert rst mid-cycle with S=ARM → Z=00 before the next clk edge. Release rst with X=00 → Z stays 00.
- Nominal sequence: from reset, X = 00, 01, 11, 01, 00, 10, 11, 01, one per cycle → Z = 00, 00, 11, 10, 10, 01, 00, 00. Repeat the sequence a second time → same Z values.
- Exhaustive transitions: for each of the 4 states, apply each of the 4 X values for one cycle. Check the next Z against the transition list (16 cases).
- Holds: ARM with X=11 for 5 cycles → Z=11 throughout. HOLD with X=01 for 5 cycles → 10. FIRE with X=10 for 5 cycles → 01.
- Abort paths: HOLD with X=11 → 00. FIRE with X=00 → 00. Then X=11 → 11, confirming re-arm.
- Build equivalence: run all of the above with and without LOGIC1_STRUCT_EN → identical Z traces.

Source files
------------

// File: rtl/logic1.sv
// logic1: two-input, two-output Moore sequence machine.
// It watches X for the ordered pattern 11 -> {00/01} -> 10, flags each phase on
// {Z1,Z2}, and returns to idle on the closing 11.
// The state encoding is chosen so that {Z1,Z2} is the state register itself.
// The outputs are therefore registered and never depend combinationally on X.
// Build option LOGIC1_STRUCT_EN selects the implementation:
//   - defined:   two explicit async-reset flops, with gate-level next-state logic.
//   - undefined: a behavioural case statement.
// Both builds behave identically at the ports.

`ifdef LOGIC1_STRUCT_EN
// Single async-reset D flop used for each state bit in the structural build.
module logic1_dff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // State bit storage, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule
`endif

module logic1 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] X,
    output logic       Z1,
    output logic       Z2
);

`ifdef LOGIC1_STRUCT_EN

    // Current state bits and their complements.
    logic s1_r;
    logic s0_r;
    logic s1_n_s;
    logic s0_n_s;

    // Input bits and their complements.
    logic xa_s;
    logic xb_s;
    logic xa_n_s;
    logic xb_n_s;

    // Product terms of the next-state equations.
    logic t_idle_arm_s;   // IDLE & Xa & Xb
    logic t_arm_s;        // ARM
    logic t_hold_s1_s;    // HOLD & ~Xa
    logic t_arm_stay_s;   // ARM & Xa & Xb
    logic t_hold_fire_s;  // HOLD & Xa & ~Xb
    logic t_fire_stay_s;  // FIRE & Xa & ~Xb

    // Next-state bits.
    logic s1_next_s;
    logic s0_next_s;

    assign xa_s = X[1];
    assign xb_s = X[0];

    not g_n_s1 (s1_n_s, s1_r);
    not g_n_s0 (s0_n_s, s0_r);
    not g_n_xa (xa_n_s, xa_s);
    not g_n_xb (xb_n_s, xb_s);

    // S1' = (IDLE & Xa & Xb) | ARM | (HOLD & ~Xa)
    and g_t0 (t_idle_arm_s, s1_n_s, s0_n_s, xa_s, xb_s);
    and g_t1 (t_arm_s,      s1_r,   s0_r);
    and g_t2 (t_hold_s1_s,  s1_r,   s0_n_s, xa_n_s);
    or  g_s1 (s1_next_s,    t_idle_arm_s, t_arm_s, t_hold_s1_s);

    // S0' = (IDLE & Xa & Xb) | (ARM & Xa & Xb) | (HOLD & Xa & ~Xb) | (FIRE & Xa & ~Xb)
    and g_t3 (t_arm_stay_s,  s1_r,   s0_r,   xa_s, xb_s);
    and g_t4 (t_hold_fire_s, s1_r,   s0_n_s, xa_s, xb_n_s);
    and g_t5 (t_fire_stay_s, s1_n_s, s0_r,   xa_s, xb_n_s);
    or  g_s0 (s0_next_s, t_idle_arm_s, t_arm_stay_s, t_hold_fire_s, t_fire_stay_s);

    logic1_dff u_s1 (.clk(clk), .rst(rst), .d(s1_next_s), .q(s1_r));
    logic1_dff u_s0 (.clk(clk), .rst(rst), .d(s0_next_s), .q(s0_r));

    assign Z1 = s1_r;
    assign Z2 = s0_r;

`else

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ARM  = 2'b11,
        HOLD = 2'b10,
        FIRE = 2'b01
    } state_t;

    state_t state_r;

    // Pattern tracker: one transition per clock, forced to IDLE by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE:    state_r <= (X == 2'b11) ? ARM : IDLE;
                ARM:     state_r <= (X == 2'b11) ? ARM : HOLD;
                HOLD: begin
                    if (X == 2'b10) begin
                        state_r <= FIRE;
                    end else if (X == 2'b11) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                FIRE:    state_r <= (X == 2'b10) ? FIRE : IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign Z1 = state_r[1];
    assign Z2 = state_r[0];

`endif

endmodule

// File: tb/tb_logic1.sv
// Self-checking bench for logic1.
// A stimulus process drives X on the falling edge and pushes the expected
// {Z1,Z2} into a scoreboard queue. A monitor pops the queue and compares the
// DUT outputs one time unit after each rising edge.
module tb_logic1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] X   = 2'b00;
    logic       Z1;
    logic       Z2;

    logic1 dut (.clk(clk), .rst(rst), .X(X), .Z1(Z1), .Z2(Z2));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] z;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: named pattern phases, with transitions as listed.
    typedef enum int {M_IDLE, M_ARM, M_HOLD, M_FIRE} mstate_t;
    mstate_t m = M_IDLE;

    function automatic mstate_t model_next(mstate_t s, logic [1:0] x);
        case (s)
            M_IDLE:  return (x == 2'b11) ? M_ARM : M_IDLE;
            M_ARM:   return (x == 2'b11) ? M_ARM : M_HOLD;
            M_HOLD:  return (x == 2'b10) ? M_FIRE : ((x == 2'b11) ? M_IDLE : M_HOLD);
            M_FIRE:  return (x == 2'b10) ? M_FIRE : M_IDLE;
            default: return M_IDLE;
        endcase
    endfunction

    function automatic logic [1:0] model_out(mstate_t s);
        case (s)
            M_IDLE:  return 2'b00;
            M_ARM:   return 2'b11;
            M_HOLD:  return 2'b10;
            M_FIRE:  return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: Z=%b expected %b at %0t", tag, act, req, $time);
        end
    endtask

    // Apply one X value for one cycle; the expected output comes from the model.
    task automatic step(input logic [1:0] x, input string tag);
        exp_t e;
        @(negedge clk);
        X = x;
        m = model_next(m, x);
        e.z = model_out(m);
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Apply one X value with an expected output given as a literal constant.
    task automatic step_const(input logic [1:0] x, input logic [1:0] z, input string tag);
        exp_t e;
        @(negedge clk);
        X = x;
        m = model_next(m, x);
        e.z = z;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Assert reset between clock edges, check that it clears immediately and
    // holds across an edge, then release it with X=00.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        X = 2'($urandom_range(0, 3));
        m = M_IDLE;
        #1;
        check("rst_async", {Z1, Z2}, 2'b00);
        @(posedge clk);
        #1;
        check("rst_hold", {Z1, Z2}, 2'b00);
        @(negedge clk);
        X = 2'b00;
        rst = 1'b0;
    endtask

    // Drive the DUT from reset into a chosen phase.
    task automatic goto_state(input int s);
        do_reset();
        if (s == 1) begin
            step(2'b11, "goto_arm");
        end else if (s == 2) begin
            step(2'b11, "goto_hold_a");
            step(2'b00, "goto_hold_b");
        end else if (s == 3) begin
            step(2'b11, "goto_fire_a");
            step(2'b00, "goto_fire_b");
            step(2'b10, "goto_fire_c");
        end
    endtask

    // Monitor: one output sample per clock, compared against the queue head.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, {Z1, Z2}, e.z);
        end
    end

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [1:0] nom_x [8] = '{2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] nom_z [8] = '{2'b00, 2'b00, 2'b11, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00};

    initial begin
        #1;
        check("reset_init", {Z1, Z2}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        step(2'b00, "rst_release");

        // Drive into ARM, then assert reset mid-cycle.
        step(2'b11, "arm_before_rst");
        do_reset();
        step(2'b00, "rst_release2");

        // Nominal sequence, run twice back to back.
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 8; i++) begin
                step_const(nom_x[i], nom_z[i], $sformatf("nominal_r%0d_%0d", rep, i));
            end
        end

        // Exhaustive transitions: every phase under every input value.
        for (int s = 0; s < 4; s++) begin
            for (int x = 0; x < 4; x++) begin
                goto_state(s);
                step(2'(x), $sformatf("trans_s%0d_x%0d", s, x));
            end
        end

        // Holds.
        goto_state(1);
        for (int i = 0; i < 5; i++) begin
            step_const(2'b11, 2'b11, "hold_arm");
        end
        goto_state(2);
        for (int i = 0; i < 5; i++) begin
            step_const(2'b01, 2'b10, "hold_hold");
        end
        goto_state(3);
        for (int i = 0; i < 5; i++) begin
            step_const(2'b10, 2'b01, "hold_fire");
        end

        // Abort paths, then re-arm.
        goto_state(2);
        step_const(2'b11, 2'b00, "abort_hold");
        goto_state(3);
        step_const(2'b00, 2'b00, "abort_fire");
        step_const(2'b11, 2'b11, "rearm");

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                do_reset();
            end
            step(2'($urandom_range(0, 3)), "random");
        end

        // Drain the scoreboard within a bounded number of cycles.
        repeat (4) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
